// File: rtl/wb_write_arbiter.sv
// Two-source writeback arbiter for the single register-file write port.
// Each source has a 1-entry buffer; grants alternate round-robin under contention.

module wb_src_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_reg,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_grant,
    output logic              o_ready,
    output logic              o_full,
    output logic [ADDR_W-1:0] o_reg,
    output logic [DATA_W-1:0] o_data
);
    logic w_accept;

    // A granted entry leaves on this edge, so the slot can refill at once.
    assign o_ready  = !o_full || i_grant;
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_full <= 1'b0;
            o_reg  <= '0;
            o_data <= '0;
        end else begin
            if (w_accept) begin
                o_full <= 1'b1;
                o_reg  <= i_reg;
                o_data <= i_data;
            end else if (i_grant) begin
                o_full <= 1'b0;
            end
        end
    end
endmodule

module wb_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic              hazard,
    output logic              WB,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic [CNT_W-1:0]  conflict_cnt
);
    localparam int NUM_SRC = 2;  // index 0 = ALU, 1 = MEM

    logic [NUM_SRC-1:0]             w_valid, w_ready, w_full, w_gnt;
    logic [NUM_SRC-1:0][ADDR_W-1:0] w_reg_in, w_reg;
    logic [NUM_SRC-1:0][DATA_W-1:0] w_data_in, w_data;
    logic                           r_last_mem;
    logic                           w_sel;
    logic                           w_hit1, w_hit2;

    assign w_valid   = {mem_valid, alu_valid};
    assign w_reg_in  = {mem_reg, alu_reg};
    assign w_data_in = {mem_data, alu_data};
    assign alu_ready = w_ready[0];
    assign mem_ready = w_ready[1];

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            wb_src_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf (
                .clk     (clk),
                .rst     (reset),
                .i_valid (w_valid[g]),
                .i_reg   (w_reg_in[g]),
                .i_data  (w_data_in[g]),
                .i_grant (w_gnt[g]),
                .o_ready (w_ready[g]),
                .o_full  (w_full[g]),
                .o_reg   (w_reg[g]),
                .o_data  (w_data[g])
            );
        end
    endgenerate

    // Under contention the source that did not win last time is granted.
    assign w_gnt[0] = w_full[0] && (!w_full[1] || r_last_mem);
    assign w_gnt[1] = w_full[1] && (!w_full[0] || !r_last_mem);
    assign w_sel    = w_gnt[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WB           <= 1'b0;
            writeReg     <= '0;
            writeData    <= '0;
            r_last_mem   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            if (|w_gnt) begin
                WB         <= (w_reg[w_sel] != '0);
                writeReg   <= w_reg[w_sel];
                writeData  <= w_data[w_sel];
                r_last_mem <= w_sel;
            end else begin
                WB <= 1'b0;
            end
            if ((&w_full) && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    always_comb begin
        w_hit1 = (readReg1 != '0) &&
                 ((w_full[0] && readReg1 == w_reg[0]) ||
                  (w_full[1] && readReg1 == w_reg[1]) ||
                  (WB && readReg1 == writeReg));
        w_hit2 = (readReg2 != '0) &&
                 ((w_full[0] && readReg2 == w_reg[0]) ||
                  (w_full[1] && readReg2 == w_reg[1]) ||
                  (WB && readReg2 == writeReg));
    end

    assign hazard = w_hit1 || w_hit2;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed steps plus randomized traffic checked
// against a queue-based model of the two writeback sources.
module tb_wb_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] alu_reg = '0, mem_reg = '0, readReg1 = '0, readReg2 = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready, hazard, WB;
    logic [AW-1:0] writeReg;
    logic [DW-1:0] writeData;
    logic [CW-1:0] conflict_cnt;

    wb_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .readReg1(readReg1), .readReg2(readReg2), .hazard(hazard),
        .WB(WB), .writeReg(writeReg), .writeData(writeData), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] r; logic [DW-1:0] d; } wr_t;

    // Model: each source holds at most one pending write in its queue.
    wr_t           q_alu[$], q_mem[$];
    int            m_last;      // 0 = ALU won last, 1 = MEM won last
    logic          m_wb;
    logic [AW-1:0] m_wreg;
    logic [DW-1:0] m_wdata;
    int            m_cnt;
    bit            m_ra = 1'b1, m_rm = 1'b1;
    int            checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_grant();
        if (q_alu.size() != 0 && q_mem.size() != 0) return (m_last == 1) ? 0 : 1;
        if (q_alu.size() != 0) return 0;
        if (q_mem.size() != 0) return 1;
        return -1;
    endfunction

    function automatic bit m_hit(input logic [AW-1:0] q);
        if (q == 0) return 1'b0;
        if (q_alu.size() != 0 && q_alu[0].r == q) return 1'b1;
        if (q_mem.size() != 0 && q_mem[0].r == q) return 1'b1;
        if (m_wb && m_wreg == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear();
        q_alu.delete(); q_mem.delete();
        m_last = 1; m_wb = 1'b0; m_wreg = '0; m_wdata = '0; m_cnt = 0;
        m_ra = 1'b1; m_rm = 1'b1;
    endtask

    // Check one cycle at the falling edge, then advance the model across the rising edge.
    task automatic step();
        int  g;
        wr_t w;
        @(negedge clk);
        g    = m_grant();
        m_ra = (q_alu.size() == 0) || (g == 0);
        m_rm = (q_mem.size() == 0) || (g == 1);
        chk("alu_ready", alu_ready, m_ra);
        chk("mem_ready", mem_ready, m_rm);
        chk("WB", WB, m_wb);
        chk("writeReg", writeReg, m_wreg);
        chk("writeData", writeData, m_wdata);
        chk("conflict_cnt", conflict_cnt, m_cnt);
        chk("hazard", hazard, m_hit(readReg1) || m_hit(readReg2));
        if (q_alu.size() != 0 && q_mem.size() != 0 && m_cnt < CMAX) m_cnt++;
        if (g >= 0) begin
            w       = (g == 0) ? q_alu.pop_front() : q_mem.pop_front();
            m_wb    = (w.r != 0);
            m_wreg  = w.r;
            m_wdata = w.d;
            m_last  = g;
        end else begin
            m_wb = 1'b0;
        end
        if (alu_valid && m_ra) q_alu.push_back('{r: alu_reg, d: alu_data});
        if (mem_valid && m_rm) q_mem.push_back('{r: mem_reg, d: mem_data});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        alu_valid = 1'b0; mem_valid = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst_WB_async", WB, 1'b0);
        chk("rst_cnt_async", conflict_cnt, 0);
        m_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Randomised source behaviour that respects the hold-while-not-ready rule.
    task automatic rand_cycle(input int pct_alu, input int pct_mem);
        if (!(alu_valid && !m_ra)) begin
            alu_valid = ($urandom_range(0, 99) < pct_alu);
            alu_reg   = AW'($urandom_range(0, 7));
            alu_data  = $urandom;
        end
        if (!(mem_valid && !m_rm)) begin
            mem_valid = ($urandom_range(0, 99) < pct_mem);
            mem_reg   = AW'($urandom_range(0, 7));
            mem_data  = $urandom;
        end
        readReg1 = AW'($urandom_range(0, 7));
        readReg2 = AW'($urandom_range(0, 7));
        step();
    endtask

    initial begin
        m_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset
        readReg1 = 5'd9;
        repeat (3) step();

        // ALU alone: reg 9 <- 5
        alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'd5;
        step();
        alu_valid = 1'b0;
        repeat (4) step();

        // Simultaneous ALU(10,3) and MEM(11,4)
        alu_valid = 1'b1; alu_reg = 5'd10; alu_data = 32'd3;
        mem_valid = 1'b1; mem_reg = 5'd11; mem_data = 32'd4;
        readReg1 = 5'd11; readReg2 = 5'd10;
        step();
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (4) step();

        // Continuous streaming from both sources, long enough to saturate the counter
        for (int i = 0; i < 22; i++) rand_cycle(100, 100);

        // Reset while both buffers are full and a write is on the port
        do_reset();
        readReg1 = 5'd10; readReg2 = 5'd11;
        repeat (3) step();

        // Register 0 write is consumed without WB
        alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'd77;
        readReg1 = 5'd0; readReg2 = 5'd0;
        step();
        alu_valid = 1'b0;
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 400; i++) rand_cycle(55, 45);
        alu_valid = 1'b0; mem_valid = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
